// File: rtl/inst_encoder_if.sv
// Shared encoder constants/bundles and the request/result interface.
// The producer/consumer side uses master, the encoder uses slave.
package inst_encoder_pkg;
  parameter int INST_WIDTH = 32;
  parameter int DATA_WIDTH = 32;

  parameter logic [2:0] IMM_I_TYPE = 3'd0;
  parameter logic [2:0] IMM_S_TYPE = 3'd1;
  parameter logic [2:0] IMM_B_TYPE = 3'd2;
  parameter logic [2:0] IMM_J_TYPE = 3'd3;
  parameter logic [2:0] IMM_U_TYPE = 3'd4;

  typedef struct packed {
    logic [2:0]            ctrl;
    logic [INST_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] imm;
  } s1_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic                  err;
  } s2_t;
endpackage

interface inst_encoder_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_imm_ctrl;
  logic [31:0] i_base;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  modport master (
    output i_valid, i_imm_ctrl,
    output i_base, i_imm, i_ready,
    input  o_ready, o_valid,
    input  o_inst, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_imm_ctrl,
    input  i_base, i_imm, i_ready,
    output o_ready, o_valid,
    output o_inst, o_err, o_err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I immediate packer: scatters a signed immediate into the
// format fields of a skeleton word, two-stage elastic pipeline.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  inst_encoder_if.slave bus
);

  logic       s1_valid;
  logic       s2_valid;
  s1_t        s1_q;
  s2_t        s2_q;
  s2_t        s2_d;
  logic [7:0] err_cnt;
  logic       s1_load;
  logic       s2_load;
  logic       out_fire;
  logic       fit12;
  logic       fit13;
  logic       fit21;

  assign s2_load  = ~s2_valid | bus.i_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign out_fire = s2_valid & bus.i_ready;

  assign bus.o_ready   = s1_load;
  assign bus.o_valid   = s2_valid;
  assign bus.o_inst    = s2_q.inst;
  assign bus.o_err     = s2_q.err;
  assign bus.o_err_cnt = err_cnt;

  // Sign-extension checks: upper bits must all match the field MSB.
  assign fit12 = &s1_q.imm[31:11] | ~|s1_q.imm[31:11];
  assign fit13 = &s1_q.imm[31:12] | ~|s1_q.imm[31:12];
  assign fit21 = &s1_q.imm[31:20] | ~|s1_q.imm[31:20];

  always_comb begin
    s2_d.inst = s1_q.base;
    s2_d.err  = 1'b1;
    unique case (1'b1)
      s1_q.ctrl == IMM_I_TYPE: begin
        s2_d.inst = {s1_q.imm[11:0], s1_q.base[19:0]};
        s2_d.err  = ~fit12;
      end
      s1_q.ctrl == IMM_S_TYPE: begin
        s2_d.inst = {s1_q.imm[11:5], s1_q.base[24:12],
                     s1_q.imm[4:0], s1_q.base[6:0]};
        s2_d.err  = ~fit12;
      end
      s1_q.ctrl == IMM_B_TYPE: begin
        s2_d.inst = {s1_q.imm[12], s1_q.imm[10:5],
                     s1_q.base[24:12], s1_q.imm[4:1],
                     s1_q.imm[11], s1_q.base[6:0]};
        s2_d.err  = ~fit13 | s1_q.imm[0];
      end
      s1_q.ctrl == IMM_J_TYPE: begin
        s2_d.inst = {s1_q.imm[20], s1_q.imm[10:1],
                     s1_q.imm[11], s1_q.imm[19:12],
                     s1_q.base[11:0]};
        s2_d.err  = ~fit21 | s1_q.imm[0];
      end
      s1_q.ctrl == IMM_U_TYPE: begin
        s2_d.inst = {s1_q.imm[31:12], s1_q.base[11:0]};
        s2_d.err  = |s1_q.imm[11:0];
      end
      default: begin
        s2_d.inst = s1_q.base;
        s2_d.err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      err_cnt  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= bus.i_valid;
        if (bus.i_valid)
          s1_q <= '{ctrl: bus.i_imm_ctrl,
                    base: bus.i_base,
                    imm:  bus.i_imm};
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_q <= s2_d;
      end
      if (out_fire && s2_q.err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RV32I immediate packer: accepts an instruction skeleton, an immediate-format select, and a 32-bit signed immediate, and produces the 32-bit instruction word with the immediate scattered into its format-specific bit fields. It is the inverse of the immediate generator, and both blocks share the `IMM_*_TYPE` select encoding. It sits in the program-loader/self-test path, feeding instruction memory. It also range-checks each immediate and flags any value that cannot be encoded.

## Interface
- No parameters; widths use `INST_WIDTH`/`DATA_WIDTH` (32).
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request this cycle
- i_imm_ctrl  in  3  format select, `IMM_I/S/B/J/U_TYPE`
- i_base  in  32  skeleton word: opcode/rd/rs1/rs2/funct fields; immediate-field bits ignored
- i_imm  in  32  signed immediate (U-type: full value, low 12 bits expected zero)
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_inst  out  32  encoded instruction
- o_err  out  1  qualifies o_inst: immediate out of range, misaligned, or illegal select
- o_err_cnt  out  8  saturating count of accepted-out results with o_err=1

## Operation
- Field masks (bits cleared from i_base, then ORed with immediate bits):
  - I: inst[31:20] = imm[11:0].
  - S: inst[31:25] = imm[11:5]; inst[11:7] = imm[4:0].
  - B: inst[31] = imm[12]; inst[7] = imm[11]; inst[30:25] = imm[10:5]; inst[11:8] = imm[4:1].
  - J: inst[31] = imm[20]; inst[19:12] = imm[19:12]; inst[20] = imm[11]; inst[30:21] = imm[10:1].
  - U: inst[31:12] = imm[31:12].
- Error conditions (instruction still emitted from truncated bits):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] ≠ 0.
  - Any other select: o_inst = i_base unchanged, o_err = 1.
- Stage 1 (S1) registers the request and computes the error flag. Stage 2 (S2) registers the packed word and the flag.
- Elastic pipeline: a stage loads when it is empty or its contents move on in the same cycle.
  - o_ready = ~s1_valid | ~s2_valid | i_ready.
  - A request transfers on i_valid & o_ready; a result transfers on o_valid & i_ready.
- o_err_cnt increments on each result transfer with o_err = 1, and saturates at 255.

## Timing
- Reset: o_valid = 0, o_err = 0, o_inst = 0, o_err_cnt = 0, both stages empty. o_ready = 1 in the first cycle after reset.
- Latency: request accepted at edge N → o_valid at edge N+2 when no stall.
- Throughput: 1 per cycle while i_ready = 1.
- Backpressure: while o_valid & ~i_ready, o_inst and o_err hold stable. S1 may still fill; once both stages are full, o_ready = 0.
- Simultaneous accept and output in one cycle: both happen with no bubble and no loss.
- i_rst asserted mid-stream: all in-flight requests are discarded, o_err_cnt clears, and the reset values appear on the next edge.
- Result order equals request order. No result is dropped or duplicated.

## Test plan
- Stream the following back-to-back with i_ready = 1; each o_inst must appear 2 cycles after its request, with o_err = 0:
  - I: base 0x00000013, imm 0xFFFFFFFF → 0xFFF00013.
  - S: base 0x00112023, imm 8 → 0x00112423.
  - B: base 0x00000063, imm 8 → 0x00000463.
  - J: base 0x0000006F, imm −4 → 0xFFDFF06F.
  - U: base 0x000000B7, imm 0x12345000 → 0x123450B7.
- J base 0x0000006F, imm 2048 → 0x0010006F, o_err = 0. Same with imm 2050 → no error. Imm 3 → o_err = 1.
- Error path:
  - I base 0x00000013, imm 2048 → 0x80000013, o_err = 1, o_err_cnt 0 → 1.
  - Illegal select → o_inst = base, o_err = 1.
  - U imm 0x00000001 → o_err = 1.
- Backpressure: hold i_ready = 0 for 5 cycles while issuing 4 requests.
  - o_ready must fall after 2 requests are accepted.
  - Outputs must stay stable while stalled.
  - After release, all results must emerge in order, none lost.
- Saturation: drive 260 erroneous results → o_err_cnt = 255.
- Reset mid-stream: assert i_rst with both stages full → next cycle o_valid = 0, o_err_cnt = 0, o_ready = 1. No stale result may appear afterward.
